// File: rtl/approx_mult_ctrl_if.sv
// Handshake and datapath-control bundle between the approximate-multiplier
// controller and its datapath and requester.
interface approx_mult_ctrl_if #(
    parameter int SHW = 4
);
    logic           start;
    logic           a_msb;
    logic           b_msb;
    logic           a_zero;
    logic           b_zero;
    logic           ld_a;
    logic           ld_b;
    logic           sh_a;
    logic           sh_b;
    logic           res_zero;
    logic           res_ld;
    logic [SHW-1:0] res_shamt;
    logic           busy;
    logic           done;

    // master: requester/datapath side, drives start and the operand flags
    modport master (
        output start, a_msb, b_msb, a_zero, b_zero,
        input  ld_a, ld_b, sh_a, sh_b, res_zero, res_ld, res_shamt, busy, done
    );

    modport slave (
        input  start, a_msb, b_msb, a_zero, b_zero,
        output ld_a, ld_b, sh_a, sh_b, res_zero, res_ld, res_shamt, busy, done
    );
endinterface

// File: rtl/approx_mult_ctrl.sv
// Sequencer for the dynamic-truncation approximate multiplier: loads operands,
// normalises them, waits out the multiplier and re-aligns the truncated product.
module approx_mult_ctrl #(
    parameter int WIDTH    = 8,
    parameter int KEEP     = 4,
    parameter int MULT_LAT = 1,
    parameter int SHW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    approx_mult_ctrl_if.slave  bus
);
    localparam int MAXSH = WIDTH - KEEP;
    localparam int CW    = (MAXSH < 1) ? 1 : $clog2(MAXSH + 1);
    localparam int WW    = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT);

    localparam logic [CW-1:0]  MAXSH_C = CW'(MAXSH);
    localparam logic [WW-1:0]  LAST_W  = WW'(MULT_LAT - 1);
    localparam logic [SHW-1:0] SH_FULL = SHW'(2 * MAXSH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_NORM  = 3'd2,
        S_ZERO  = 3'd3,
        S_MULT  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_a_q;
    logic [CW-1:0]  cnt_b_q;
    logic [WW-1:0]  wait_q;
    logic [SHW-1:0] shamt_q;

    logic           any_zero;
    logic           sh_a_en;
    logic           sh_b_en;
    logic [SHW-1:0] shamt_calc;

    // Shift enables follow the live MSB flags so one bit moves per NORM cycle.
    assign any_zero   = bus.a_zero | bus.b_zero;
    assign sh_a_en    = (state_q == S_NORM) && !any_zero && !bus.a_msb && (cnt_a_q < MAXSH_C);
    assign sh_b_en    = (state_q == S_NORM) && !any_zero && !bus.b_msb && (cnt_b_q < MAXSH_C);
    assign shamt_calc = SH_FULL - SHW'(cnt_a_q) - SHW'(cnt_b_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            wait_q  <= '0;
            shamt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_LOAD;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        shamt_q <= '0;
                    end
                end
                S_LOAD:  state_q <= S_NORM;
                S_NORM: begin
                    if (any_zero) begin
                        state_q <= S_ZERO;
                    end else if (!sh_a_en && !sh_b_en) begin
                        state_q <= S_MULT;
                        wait_q  <= '0;
                        shamt_q <= shamt_calc;
                    end else begin
                        cnt_a_q <= cnt_a_q + CW'(sh_a_en);
                        cnt_b_q <= cnt_b_q + CW'(sh_b_en);
                    end
                end
                S_ZERO:  state_q <= S_DONE;
                S_MULT: begin
                    if (wait_q == LAST_W) state_q <= S_WRITE;
                    else                  wait_q  <= wait_q + WW'(1);
                end
                S_WRITE: state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ld_a      = (state_q == S_LOAD);
    assign bus.ld_b      = (state_q == S_LOAD);
    assign bus.sh_a      = sh_a_en;
    assign bus.sh_b      = sh_b_en;
    assign bus.res_zero  = (state_q == S_ZERO);
    assign bus.res_ld    = (state_q == S_WRITE);
    assign bus.res_shamt = shamt_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);

    a_cnt_a_cap: assert property (@(posedge clk) disable iff (rst) cnt_a_q <= MAXSH_C);
    a_cnt_b_cap: assert property (@(posedge clk) disable iff (rst) cnt_b_q <= MAXSH_C);
    a_done_one:  assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);
endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Bench for approx_mult_ctrl: two instances (MULT_LAT 1 and 3) run side by side
// against a small datapath and an arithmetic reference of the operation.
module tb_approx_mult_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;

    logic [1:0][11:0] outv;
    logic [1:0][17:0] res_v;
    logic [1:0]       amsb_v;
    logic [1:0]       bmsb_v;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int ML = (g == 0) ? 1 : 3;
        logic [7:0]  ra, rb;
        logic [17:0] res;
        approx_mult_ctrl_if #(.SHW(4)) bus ();
        approx_mult_ctrl #(.WIDTH(8), .KEEP(4), .MULT_LAT(ML), .SHW(4)) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
        assign bus.start  = start;
        assign bus.a_msb  = ra[7];
        assign bus.b_msb  = rb[7];
        assign bus.a_zero = (ra == 8'd0);
        assign bus.b_zero = (rb == 8'd0);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ra <= '0; rb <= '0; res <= '0;
            end else begin
                if (bus.ld_a) ra <= a_in; else if (bus.sh_a) ra <= {ra[6:0], 1'b0};
                if (bus.ld_b) rb <= b_in; else if (bus.sh_b) rb <= {rb[6:0], 1'b0};
                if (bus.res_zero)    res <= '0;
                else if (bus.res_ld) res <= ({14'd0, ra[7:4]} * {14'd0, rb[7:4]}) << bus.res_shamt;
            end
        end
        assign outv[g]   = {bus.ld_a, bus.ld_b, bus.sh_a, bus.sh_b, bus.res_zero, bus.res_ld,
                            bus.busy, bus.done, bus.res_shamt};
        assign res_v[g]  = res;
        assign amsb_v[g] = ra[7];
        assign bmsb_v[g] = rb[7];
    end

    typedef struct {
        int shamt, res, done_c, ld_c, nsa, nsb, rz, msba, msbb;
    } exp_t;

    typedef struct {
        logic [7:0] a, b;
        int shamt, res, done1, done3;
    } vec_t;

    int m_done[2], m_rld[2], m_sha[2], m_shb[2], m_shamt[2], m_res[2];
    int m_rz[2], m_ld[2], m_busy[2], m_msba[2], m_msbb[2];
    int opn = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: count leading zeros up to the cap, multiply the top nibbles,
    // shift back by the bits that were dropped.
    function automatic exp_t model(input int a, input int b, input int ml);
        exp_t e;
        int na, nb;
        e = '{default: 0};
        if (a == 0 || b == 0) begin
            e.done_c = 4;
            e.rz     = 1;
            e.msba   = (a >= 128);
            e.msbb   = (b >= 128);
            return e;
        end
        na = a; nb = b;
        while (na < 128 && e.nsa < 4) begin na = na * 2; e.nsa++; end
        while (nb < 128 && e.nsb < 4) begin nb = nb * 2; e.nsb++; end
        e.shamt  = 8 - e.nsa - e.nsb;
        e.res    = ((na / 16) * (nb / 16)) << e.shamt;
        e.done_c = 1 + ((e.nsa > e.nsb ? e.nsa : e.nsb) + 1) + ml + 1 + 1;
        e.ld_c   = e.done_c - 1;
        e.msba   = (na >= 128);
        e.msbb   = (nb >= 128);
        return e;
    endfunction

    // Called on a negedge with both instances idle; returns on a negedge with both idle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit noise);
        exp_t e;
        logic [11:0] o;
        opn++;
        for (int g = 0; g < 2; g++) begin
            m_done[g] = 0; m_rld[g] = 0; m_sha[g] = 0; m_shb[g] = 0; m_shamt[g] = -1;
            m_res[g] = -1; m_rz[g] = 0; m_ld[g] = 0; m_busy[g] = 0; m_msba[g] = -1; m_msbb[g] = -1;
        end
        a_in = a; b_in = b; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = noise && (cyc == 2 || cyc == 3);
            for (int g = 0; g < 2; g++) begin
                o = outv[g];
                if (m_done[g] == 0) begin
                    m_ld[g]   += int'(o[11]);
                    m_sha[g]  += int'(o[9]);
                    m_shb[g]  += int'(o[8]);
                    m_rz[g]   += int'(o[7]);
                    m_busy[g] += int'(o[5]);
                    if (o[6]) m_rld[g] = cyc;
                    if (o[4]) begin
                        m_done[g]  = cyc;
                        m_shamt[g] = int'(o[3:0]);
                        m_res[g]   = int'(res_v[g]);
                        m_msba[g]  = int'(amsb_v[g]);
                        m_msbb[g]  = int'(bmsb_v[g]);
                    end
                end
            end
            if (m_done[0] != 0 && m_done[1] != 0) break;
        end
        start = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            e = model(int'(a), int'(b), (g == 0) ? 1 : 3);
            chk($sformatf("done_cycle op%0d dut%0d", opn, g), m_done[g], e.done_c);
            chk($sformatf("res_ld_cycle op%0d dut%0d", opn, g), m_rld[g], e.ld_c);
            chk($sformatf("sh_a_count op%0d dut%0d", opn, g), m_sha[g], e.nsa);
            chk($sformatf("sh_b_count op%0d dut%0d", opn, g), m_shb[g], e.nsb);
            chk($sformatf("res_shamt op%0d dut%0d", opn, g), m_shamt[g], e.shamt);
            chk($sformatf("result op%0d dut%0d", opn, g), m_res[g], e.res);
            chk($sformatf("res_zero_count op%0d dut%0d", opn, g), m_rz[g], e.rz);
            chk($sformatf("ld_count op%0d dut%0d", opn, g), m_ld[g], 1);
            chk($sformatf("busy_cycles op%0d dut%0d", opn, g), m_busy[g], e.done_c);
            chk($sformatf("a_msb_final op%0d dut%0d", opn, g), m_msba[g], e.msba);
            chk($sformatf("b_msb_final op%0d dut%0d", opn, g), m_msbb[g], e.msbb);
            chk($sformatf("idle_after op%0d dut%0d", opn, g), int'(outv[g][5]), 0);
        end
    endtask

    initial begin
        vec_t tbl[4];
        int ldn[2], lc[2][3], idl[2];
        logic [7:0] ra_r, rb_r;

        tbl[0] = '{a: 8'h13, b: 8'h80, shamt: 5, res: 2304,  done1: 8, done3: 10};
        tbl[1] = '{a: 8'h05, b: 8'h03, shamt: 0, res: 15,    done1: 9, done3: 11};
        tbl[2] = '{a: 8'h00, b: 8'hFF, shamt: 0, res: 0,     done1: 4, done3: 4};
        tbl[3] = '{a: 8'hFF, b: 8'hFF, shamt: 8, res: 57600, done1: 5, done3: 7};

        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) chk($sformatf("reset_outputs dut%0d", g), int'(outv[g]), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].a, tbl[i].b, 1'b0);
            chk($sformatf("tbl%0d shamt", i), m_shamt[0], tbl[i].shamt);
            chk($sformatf("tbl%0d result", i), m_res[0], tbl[i].res);
            chk($sformatf("tbl%0d done_ml1", i), m_done[0], tbl[i].done1);
            chk($sformatf("tbl%0d done_ml3", i), m_done[1], tbl[i].done3);
        end

        // Reset in the middle of normalisation.
        a_in = 8'h01; b_in = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_norm sh_a", int'(outv[0][9]), 1);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) chk($sformatf("async_reset_outputs dut%0d", g), int'(outv[g]), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_op(8'h13, 8'h80, 1'b0);

        // Extra start pulses while busy.
        run_op(8'h01, 8'h01, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);

        // Start held high: one load per operation, one idle cycle between.
        a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        ldn = '{0, 0}; idl = '{0, 0}; lc = '{'{0, 0, 0}, '{0, 0, 0}};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (outv[g][11]) begin
                    if (ldn[g] < 3) lc[g][ldn[g]] = cyc;
                    ldn[g]++;
                end
                if (ldn[g] >= 1 && ldn[g] < 3 && !outv[g][5]) idl[g]++;
            end
            if (ldn[0] >= 3 && ldn[1] >= 3) break;
        end
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("held_start first_load dut%0d", g), lc[g][0], 1);
            chk($sformatf("held_start period1 dut%0d", g), lc[g][1] - lc[g][0], (g == 0) ? 6 : 8);
            chk($sformatf("held_start period2 dut%0d", g), lc[g][2] - lc[g][1], (g == 0) ? 6 : 8);
            chk($sformatf("held_start idle_cycles dut%0d", g), idl[g], 2);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (!outv[0][5] && !outv[1][5]) break;
        end
        chk("drain_idle", int'({outv[0][5], outv[1][5]}), 0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            ra_r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            rb_r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            run_op(ra_r, rb_r, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
